// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: decode-side request and HI/LO result bundle for muldiv_unit.
//   en, Rtype, func : instruction valid, R-type flag and function field
//   a, b            : rs / rt operands
//   busy, stall     : iterative op in flight / core must hold this cycle
//   hilo_rdata      : mfhi/mflo read data
//   hi, lo          : architectural HI/LO registers
interface muldiv_unit_if #(
  parameter int W = 32
);
  logic         en;
  logic         Rtype;
  logic [5:0]   func;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         stall;
  logic [W-1:0] hilo_rdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output en, Rtype, func, a, b,
    input  busy, stall, hilo_rdata, hi, lo
  );

  modport slave (
    input  en, Rtype, func, a, b,
    output busy, stall, hilo_rdata, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS32 multiply/divide unit with HI/LO registers.
// mult/multu/div/divu take W cycles (one bit per cycle); mfhi/mflo/mthi/mtlo
// are serviced in the decode cycle when idle. stall holds the core while a
// HI/LO-related instruction arrives during an operation.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if slave (request fields in, busy/stall/HI/LO out)
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         r_state, w_state_nxt;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;     // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [W-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic           r_div;
  logic           r_neg_q;   // negate product / quotient at the end
  logic           r_neg_r;   // negate remainder at the end
  logic [W-1:0]   r_hi, r_lo;

  logic           w_dec, w_md, w_hl, w_start, w_busy, w_last, w_signed;
  logic           w_mthi, w_mtlo, w_mfhi, w_mflo;
  logic [W-1:0]   w_abs_a, w_abs_b;
  logic [W:0]     w_msum, w_rsh, w_trial;
  logic [2*W-1:0] w_step, w_prod;
  logic [W-1:0]   w_q, w_r;

  // Decode
  assign w_dec    = bus.en & bus.Rtype;
  assign w_md     = (bus.func[5:2] == 4'b0110);
  assign w_hl     = (bus.func[5:2] == 4'b0100);
  assign w_mfhi   = w_dec & (bus.func == 6'b010000);
  assign w_mthi   = w_dec & (bus.func == 6'b010001);
  assign w_mflo   = w_dec & (bus.func == 6'b010010);
  assign w_mtlo   = w_dec & (bus.func == 6'b010011);
  assign w_signed = ~bus.func[0];
  assign w_start  = (r_state == IDLE) & w_dec & w_md;
  assign w_last   = (r_state == RUN) & (r_cnt == CW'(W-1));

  assign w_abs_a = (w_signed & bus.a[W-1]) ? -bus.a : bus.a;
  assign w_abs_b = (w_signed & bus.b[W-1]) ? -bus.b : bus.b;

  // One iteration: shift-add for mul, restoring shift-subtract for div
  assign w_msum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_rsh   = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_trial = w_rsh - {1'b0, r_opnd};

  always_comb begin
    w_step = '0;
    if (r_div) begin
      if (w_trial[W]) w_step = {w_rsh[W-1:0], r_acc[W-2:0], 1'b0};
      else            w_step = {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
    end else begin
      w_step = {w_msum, r_acc[W-1:1]};
    end
  end

  // Sign fix-up applied only on the completing edge
  assign w_prod = r_neg_q ? -w_step : w_step;
  assign w_q    = r_neg_q ? -w_step[W-1:0] : w_step[W-1:0];
  assign w_r    = r_neg_r ? -w_step[2*W-1:W] : w_step[2*W-1:W];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_start) w_state_nxt = RUN;
      RUN:  if (w_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy         = (r_state == RUN);
    bus.busy       = w_busy;
    bus.stall      = w_busy & w_dec & (w_md | w_hl);
    bus.hilo_rdata = '0;
    if (!w_busy) begin
      if (w_mfhi)      bus.hilo_rdata = r_hi;
      else if (w_mflo) bus.hilo_rdata = r_lo;
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_acc   <= {{W{1'b0}}, w_abs_a};
      r_opnd  <= w_abs_b;
      r_div   <= bus.func[1];
      // Divide by zero keeps the all-ones quotient unsigned-looking
      r_neg_q <= w_signed & (bus.a[W-1] ^ bus.b[W-1]) & ~(bus.func[1] & (bus.b == '0));
      r_neg_r <= w_signed & bus.a[W-1] & bus.func[1];
    end else if (w_busy) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        if (r_div) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end else begin
          r_hi <= w_prod[2*W-1:W];
          r_lo <= w_prod[W-1:0];
        end
      end
    end else begin
      if (w_mthi) r_hi <= bus.a;
      if (w_mtlo) r_lo <= bus.a;
    end
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADDU  = 6'b100001;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  muldiv_unit_if #(.W(32)) bus ();
  muldiv_unit #(.W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one mul/div from idle and count the cycles busy stays high
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    @(negedge clk);
    bus.en = 1'b1; bus.Rtype = 1'b1; bus.func = f; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.en = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[10];
  int   cyc;
  int   n;

  initial begin
    vecs[0] = '{F_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
    vecs[3] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[6] = '{F_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[7] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[9] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    bus.en = 1'b0; bus.Rtype = 1'b0; bus.func = '0; bus.a = '0; bus.b = '0;
    #12;
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);
    chk("reset_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].func, vecs[i].a, vecs[i].b, cyc);
      chk($sformatf("v%0d_cycles", i), cyc, 32'd32);
      chk($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
    end

    // mflo right after a mult; en=0 must read zero
    run_op(F_MULT, 32'h7, 32'hFFFFFFFD, cyc);
    bus.en = 1'b1; bus.Rtype = 1'b1; bus.func = F_MFLO; #1;
    chk("mflo_rdata", bus.hilo_rdata, 32'hFFFFFFEB);
    chk("mflo_stall", {31'b0, bus.stall}, 32'h0);
    bus.en = 1'b0; #1;
    chk("noreq_rdata", bus.hilo_rdata, 32'h0);

    // mthi / mtlo single-edge writes
    @(negedge clk);
    bus.en = 1'b1; bus.func = F_MTHI; bus.a = 32'hAAAA0000;
    @(negedge clk);
    chk("mthi_hi", bus.hi, 32'hAAAA0000);
    bus.func = F_MTLO; bus.a = 32'h00005555;
    @(negedge clk);
    chk("mtlo_lo", bus.lo, 32'h00005555);
    chk("mtlo_hi_keep", bus.hi, 32'hAAAA0000);
    bus.en = 1'b0;

    // Stall: mult running, mfhi from cycle 5, addu and a stalled mthi mid-run
    @(negedge clk);
    bus.en = 1'b1; bus.func = F_MULT; bus.a = 32'h7; bus.b = 32'hFFFFFFFD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.en = 1'b0;
    end
    bus.en = 1'b1; bus.a = 32'hDEADBEEF;
    n = 0;
    bus.func = F_MFHI; #1;
    while (bus.busy && n < 100) begin
      chk("run_stall", {31'b0, bus.stall}, 32'h1);
      chk("run_rdata", bus.hilo_rdata, 32'h0);
      chk("run_hi_hold", bus.hi, 32'hAAAA0000);
      if (n == 5) begin
        bus.func = F_ADDU; #1;
        chk("addu_stall", {31'b0, bus.stall}, 32'h0);
      end
      bus.func = (n == 8) ? F_MTHI : F_MFHI;
      @(negedge clk); #1;
      n++;
    end
    chk("stall_done_busy", {31'b0, bus.busy}, 32'h0);
    bus.func = F_MFHI; #1;
    chk("stall_done_stall", {31'b0, bus.stall}, 32'h0);
    chk("stall_done_rdata", bus.hilo_rdata, 32'hFFFFFFFF);
    chk("stall_done_lo", bus.lo, 32'hFFFFFFEB);
    @(negedge clk);
    bus.en = 1'b0;

    // Reset mid-divide aborts without a later HI/LO write
    @(negedge clk);
    bus.en = 1'b1; bus.func = F_DIV; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_busy", {31'b0, bus.busy}, 32'h1);
    rst_n = 1'b0; #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_hi", bus.hi, 32'h0);
    chk("post_rst_lo", bus.lo, 32'h0);
    chk("post_rst_busy", {31'b0, bus.busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
